uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side sequencer for the UART. It oversamples the serial line, finds and qualifies the start bit, and drives the external `sipo_shift_register` with one `shift_en` pulse plus a sampled bit at the centre of each data bit. It then checks the optional parity bit and the stop bit, and presents the assembled byte in transmission order, LSB first, with valid and error strobes. It sits between the baud-rate generator, which supplies `sample_tick`, and the receive FIFO or host interface.

## Interface
- `OS_RATE`, default 16: `sample_tick` pulses per bit period; even, ≥4.
- `clk` input 1: single clock; all logic on rising edge.
- `arst_n` input 1: asynchronous, active-low reset.
- `sample_tick` input 1: one-`clk` pulse at OS_RATE × baud.
- `rx_in` input 1: raw serial line, asynchronous; idle high.
- `parity_en` input 1: 1 = frame carries a parity bit after D7.
- `parity_odd` input 1: 1 = odd parity, 0 = even.
- `sipo_data` input 8: `data` output of the shift register.
- `shift_en` output 1: to shift register; one-`clk` pulse per data bit.
- `sipo_bit` output 1: to shift register `rx_in`; valid while `shift_en`=1.
- `rx_data` output 8: received byte, bit i = i-th received data bit.
- `rx_valid` output 1: one-`clk` pulse; `rx_data` updated in the same cycle.
- `parity_err` output 1: one-`clk` pulse alongside `rx_valid` on parity mismatch.
- `frame_err` output 1: one-`clk` pulse when the stop bit is sampled low.
- `busy` output 1: high whenever state ≠ IDLE.

## Operation
- `rx_in` passes through a 2-flop synchroniser (reset value 1) to give `rx_s`. All decisions use `rx_s`.
- Counters:
  - `os_cnt` is $clog2(OS_RATE) bits and advances only on `sample_tick`.
  - `bit_cnt` is 3 bits.
  - `par_acc` is 1 bit: XOR of the data bits sampled so far.
- States: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- **IDLE**
  - On `sample_tick` with `rx_s`=0: go to START, `os_cnt`=0.
- **START**
  - On each tick, `os_cnt`++.
  - At the tick where `os_cnt`==OS_RATE/2−1 (bit centre):
    - `rx_s`=1: false start, go to IDLE. No strobes.
    - `rx_s`=0: go to DATA with `os_cnt`=0, `bit_cnt`=0, `par_acc`=0. Latch `parity_en` and `parity_odd`; they are ignored for the rest of the frame.
- **DATA**
  - At the tick where `os_cnt`==OS_RATE−1 (centre of the next bit):
    - register `shift_en`=1 and `sipo_bit`=`rx_s`;
    - `par_acc` ^= `rx_s`, `os_cnt`=0, `bit_cnt`++.
  - After the 8th sample (`bit_cnt` was 7): go to PARITY if the latched `parity_en`=1, else STOP.
- **PARITY**
  - At the centre tick, record mismatch = (`rx_s` ≠ `par_acc` ^ `parity_odd`).
  - Go to STOP with `os_cnt`=0.
- **STOP**
  - At the centre tick, if `rx_s`=1:
    - `rx_data` ← bit-reverse of `sipo_data` (the shifter puts the first bit in bit 7);
    - `rx_valid`=1;
    - `parity_err`=recorded mismatch, forced to 0 when parity is disabled;
    - go to IDLE.
  - If `rx_s`=0: `frame_err`=1, `rx_data` unchanged, go to WAIT_HIGH.
- **WAIT_HIGH**
  - Stay until `rx_s`=1, then go to IDLE. This covers a break or a stuck-low line, so no spurious start is taken.
- `rx_valid` and `frame_err` never assert in the same cycle.

## Timing
- Reset values: state IDLE; `shift_en`=0, `sipo_bit`=0, `rx_data`=0x00, `rx_valid`=0, `parity_err`=0, `frame_err`=0, `busy`=0; all counters 0; synchroniser flops 1.
- Reset asserted mid-frame aborts the frame immediately, with no strobes. After release, the block waits for a fresh falling edge.
- All outputs are registered. Each strobe is high in the `clk` cycle after the edge on which its sampling tick is seen.
- `shift_en` is exactly one cycle wide and `sipo_bit` is stable in that cycle.
- `sipo_data` is complete by the cycle after the 8th `shift_en`. That is at least OS_RATE ticks before the stop sample, so it is read safely.
- Frame sampling points, in ticks after the first low `rx_s` tick:
  - start centre: OS_RATE/2;
  - data bit k centre: OS_RATE/2 + (k+1)·OS_RATE;
  - stop centre: OS_RATE/2 + 9·OS_RATE, or + 10·OS_RATE with parity.
- Input-to-`rx_s` delay is 2 `clk`.
- `busy` rises the cycle after the start edge is detected and falls the cycle after return to IDLE.
- Ticks arriving while in IDLE with `rx_s`=1 have no effect. Back-to-back frames, with the next start edge immediately after the stop centre, must be received.

## Test plan
- **Normal frame.** OS_RATE=16, tick every `clk`, parity off. Send 0x4B: LSB first, 1 start bit, 1 stop bit.
  - Exactly 8 `shift_en` pulses, with `sipo_bit` sequence 1,1,0,1,0,0,1,0.
  - `sipo_data`=0xD2; then `rx_valid` with `rx_data`=0x4B, both error outputs 0.
- **Glitch rejection.** 4-tick low pulse on an idle line.
  - Return to IDLE, no `shift_en`, no strobes, `busy` high for ≤9 ticks.
- **Parity check.** `parity_en`=1, `parity_odd`=0; send 0x07.
  - Parity bit 1: `rx_valid` with `parity_err`=0.
  - Parity bit 0: `rx_valid` with `parity_err`=1 and `rx_data`=0x07.
- **Bad stop bit.** Stop bit driven low, then the line held low for 40 ticks.
  - `frame_err` pulses once, with no `rx_valid` and `rx_data` unchanged.
  - No new frame starts until the line goes high and then falls again.
- **Back-to-back and slow ticks.** `sample_tick` every 3rd `clk`; send 0x00 then 0xFF with no idle gap.
  - Two `rx_valid` pulses carrying 0x00 then 0xFF.
- **Mid-frame reset.** Assert `arst_n` after the 4th `shift_en`.
  - All outputs return to reset values asynchronously.
  - The next full frame, 0x5A, is received correctly.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: oversampling UART receive sequencer driving an external SIPO shift register
module uart_rx_ctrl #(
  parameter int OS_RATE = 16
) (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       sample_tick,
  input  logic       rx_in,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic [7:0] sipo_data,
  output logic       shift_en,
  output logic       sipo_bit,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       busy
);
  localparam int W = $clog2(OS_RATE);
  localparam logic [W-1:0] HALF_M1 = W'(OS_RATE / 2 - 1);
  localparam logic [W-1:0] FULL_M1 = W'(OS_RATE - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
  state_t state, state_d;
  logic rx_m, rx_s;
  logic [W-1:0] os_cnt, os_d;
  logic [2:0] bit_cnt, bit_d;
  logic par_acc, par_d, pen, pen_d, podd, podd_d, perr, perr_d;
  logic shift_d, sbit_d, valid_d, perr_o_d, ferr_d;
  logic [7:0] data_d, rev;
  // the shifter places the first received bit in bit 7
  for (genvar i = 0; i < 8; i++) begin : g_rev
    assign rev[i] = sipo_data[7-i];
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      state <= IDLE;
      os_cnt <= '0;
      bit_cnt <= '0;
      par_acc <= 1'b0;
      pen <= 1'b0;
      podd <= 1'b0;
      perr <= 1'b0;
      shift_en <= 1'b0;
      sipo_bit <= 1'b0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      busy <= 1'b0;
    end else begin
      rx_m <= rx_in;
      rx_s <= rx_m;
      state <= state_d;
      os_cnt <= os_d;
      bit_cnt <= bit_d;
      par_acc <= par_d;
      pen <= pen_d;
      podd <= podd_d;
      perr <= perr_d;
      shift_en <= shift_d;
      sipo_bit <= sbit_d;
      rx_data <= data_d;
      rx_valid <= valid_d;
      parity_err <= perr_o_d;
      frame_err <= ferr_d;
      busy <= state_d != IDLE;
    end
  end
  always_comb begin
    state_d = state;
    os_d = os_cnt;
    bit_d = bit_cnt;
    par_d = par_acc;
    pen_d = pen;
    podd_d = podd;
    perr_d = perr;
    shift_d = 1'b0;
    sbit_d = sipo_bit;
    data_d = rx_data;
    valid_d = 1'b0;
    perr_o_d = 1'b0;
    ferr_d = 1'b0;
    case (state)
      IDLE: if (sample_tick && !rx_s) begin
        state_d = START;
        os_d = '0;
      end
      START: if (sample_tick) begin
        os_d = os_cnt + 1'b1;
        if (os_cnt == HALF_M1) begin
          state_d = rx_s ? IDLE : DATA;
          os_d = '0;
          bit_d = '0;
          par_d = 1'b0;
          pen_d = rx_s ? pen : parity_en;
          podd_d = rx_s ? podd : parity_odd;
        end
      end
      DATA: if (sample_tick) begin
        os_d = os_cnt + 1'b1;
        if (os_cnt == FULL_M1) begin
          shift_d = 1'b1;
          sbit_d = rx_s;
          par_d = par_acc ^ rx_s;
          os_d = '0;
          bit_d = bit_cnt + 1'b1;
          state_d = bit_cnt != 3'd7 ? DATA : pen ? PARITY : STOP;
        end
      end
      PARITY: if (sample_tick) begin
        os_d = os_cnt + 1'b1;
        if (os_cnt == FULL_M1) begin
          perr_d = rx_s != (par_acc ^ podd);
          os_d = '0;
          state_d = STOP;
        end
      end
      STOP: if (sample_tick) begin
        os_d = os_cnt + 1'b1;
        if (os_cnt == FULL_M1) begin
          os_d = '0;
          data_d = rx_s ? rev : rx_data;
          valid_d = rx_s;
          perr_o_d = rx_s & pen & perr;
          ferr_d = !rx_s;
          state_d = rx_s ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with a serial-line driver and SIPO model
module tb_uart_rx_ctrl;
  localparam int OS = 16;
  logic clk = 0, arst_n = 0, sample_tick = 0, rx_in = 1, parity_en = 0, parity_odd = 0;
  logic shift_en, sipo_bit, rx_valid, parity_err, frame_err, busy;
  logic [7:0] sipo_data = 0, rx_data;
  int checks = 0, failures = 0, tick_div = 1, div_cnt = 0, shift_cnt = 0, busy_ticks = 0;
  typedef struct {logic fe; logic [7:0] d; logic pe;} ev_t;
  ev_t ev_q[$];
  logic bit_q[$];
  logic [7:0] last_data = 0;

  uart_rx_ctrl #(.OS_RATE(OS)) dut (
    .clk(clk), .arst_n(arst_n), .sample_tick(sample_tick), .rx_in(rx_in),
    .parity_en(parity_en), .parity_odd(parity_odd), .sipo_data(sipo_data),
    .shift_en(shift_en), .sipo_bit(sipo_bit), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (div_cnt >= tick_div - 1) begin
      div_cnt = 0;
      sample_tick = 1;
    end else begin
      div_cnt++;
      sample_tick = 0;
    end
  end
  // external shift register: first bit ends up in bit 7
  always @(posedge clk) if (shift_en) sipo_data <= {sipo_data[6:0], sipo_bit};

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  function automatic logic [7:0] rev8(input logic [7:0] v);
    for (int i = 0; i < 8; i++) rev8[i] = v[7-i];
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (arst_n) begin
      if (sample_tick && busy) busy_ticks++;
      if (shift_en) begin
        shift_cnt++;
        chk("shift_expected", int'(bit_q.size() > 0), 1);
        if (bit_q.size() > 0) chk("sipo_bit", int'(sipo_bit), int'(bit_q.pop_front()));
      end
      if (parity_err) chk("perr_with_valid", int'(rx_valid), 1);
      if (rx_valid || frame_err) begin
        chk("valid_ferr_exclusive", int'(rx_valid & frame_err), 0);
        chk("strobe_expected", int'(ev_q.size() > 0), 1);
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          chk("frame_err", int'(frame_err), int'(e.fe));
          chk("rx_data", int'(rx_data), int'(e.d));
          chk("parity_err", int'(parity_err), int'(e.pe));
          if (!e.fe) chk("sipo_data", int'(sipo_data), int'(rev8(e.d)));
        end
      end
    end
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!sample_tick) @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input int n);
    rx_in = b;
    repeat (n) wait_tick();
  endtask

  task automatic send(input logic [7:0] d, input logic pen, input logic podd, input logic pbit,
                      input logic stop, input int stop_len);
    parity_en = pen;
    parity_odd = podd;
    for (int k = 0; k < 8; k++) bit_q.push_back(d[k]);
    if (stop) begin
      ev_q.push_back('{1'b0, d, pen && (pbit != (^d ^ podd))});
      last_data = d;
    end else ev_q.push_back('{1'b1, last_data, 1'b0});
    drive(0, OS);
    parity_en = 1'($urandom);
    parity_odd = 1'($urandom);
    for (int k = 0; k < 8; k++) drive(d[k], OS);
    if (pen) drive(pbit, OS);
    drive(stop, stop_len);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_shift_en"}, int'(shift_en), 0);
    chk({tag, "_sipo_bit"}, int'(sipo_bit), 0);
    chk({tag, "_rx_data"}, int'(rx_data), 0);
    chk({tag, "_rx_valid"}, int'(rx_valid), 0);
    chk({tag, "_parity_err"}, int'(parity_err), 0);
    chk({tag, "_frame_err"}, int'(frame_err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int s0, t;
    logic [7:0] d, a5;
    logic pen, podd, pbit;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs("reset");
    #2 arst_n = 1;
    repeat (5) wait_tick();
    s0 = shift_cnt;
    send(8'h4B, 0, 0, 0, 1, OS);
    drive(1, 4);
    chk("normal_shift_count", shift_cnt - s0, 8);
    busy_ticks = 0;
    s0 = shift_cnt;
    drive(0, 4);
    drive(1, 12);
    chk("glitch_busy", int'(busy), 0);
    chk("glitch_busy_le9", int'(busy_ticks <= 9), 1);
    chk("glitch_shifts", shift_cnt - s0, 0);
    send(8'h07, 1, 0, 1, 1, OS);
    drive(1, 4);
    send(8'h07, 1, 0, 0, 1, OS);
    drive(1, 4);
    send(8'h3C, 0, 0, 0, 0, 1);
    drive(0, 40);
    chk("break_busy", int'(busy), 1);
    drive(1, 6);
    chk("break_released", int'(busy), 0);
    tick_div = 3;
    drive(1, 2);
    send(8'h00, 0, 0, 0, 1, OS / 2 + 4);
    send(8'hFF, 0, 0, 0, 1, OS);
    drive(1, 4);
    tick_div = 1;
    drive(1, 2);
    s0 = shift_cnt;
    a5 = 8'hA5;
    parity_en = 0;
    for (int k = 0; k < 4; k++) bit_q.push_back(a5[k]);
    drive(0, OS);
    for (int k = 0; k < 4; k++) drive(a5[k], OS);
    chk("shifts_before_reset", shift_cnt - s0, 4);
    @(posedge clk);
    #3 arst_n = 0;
    #1 chk_reset_outputs("midreset");
    rx_in = 1;
    bit_q.delete();
    last_data = 0;
    repeat (3) @(posedge clk);
    #2 arst_n = 1;
    drive(1, 20);
    send(8'h5A, 0, 0, 0, 1, OS);
    drive(1, 3);
    repeat (12) begin
      tick_div = $urandom_range(1, 3);
      d = 8'($urandom);
      pen = 1'($urandom);
      podd = 1'($urandom);
      pbit = ($urandom_range(0, 3) != 0) ? (^d ^ podd) : ~(^d ^ podd);
      send(d, pen, podd, pbit, 1, OS);
      drive(1, $urandom_range(1, 4));
    end
    t = 0;
    while ((ev_q.size() > 0 || bit_q.size() > 0) && t < 5000) begin
      @(posedge clk);
      t++;
    end
    chk("pending_strobes", ev_q.size(), 0);
    chk("pending_bits", bit_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
